// File: rtl/denoise_frame_ctrl.sv
// rtl/denoise_frame_ctrl.sv - frame statistics and adaptive threshold control for the denoise stage
// Publishes paddle vertical centres once per frame and steers the filter threshold toward a target band.
module denoise_frame_ctrl #(
   parameter int CNT_W          = 20,
   parameter int MIN_PIXELS     = 64,
   parameter int LOW_COUNT      = 400,
   parameter int HIGH_COUNT     = 6000,
   parameter int INIT_THRESHOLD = 8,
   parameter int THR_MIN        = 1,
   parameter int THR_MAX        = 15,
   parameter int DEFAULT_Y      = 240
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        vs_n,
   input  logic        blank_n,
   input  logic        left_paddle,
   input  logic        right_paddle,
   input  logic [12:0] row,
   input  logic [12:0] col,
   input  logic        manual_sw,
   input  logic [3:0]  threshold_sw,
   output logic        en_o,
   output logic [3:0]  threshold_o,
   output logic [12:0] left_y,
   output logic [12:0] right_y,
   output logic        left_valid,
   output logic        right_valid,
   output logic        frame_done
);

   localparam logic [CNT_W-1:0] MIN_T   = CNT_W'(MIN_PIXELS);
   localparam logic [CNT_W:0]   LOW_T   = (CNT_W+1)'(LOW_COUNT);
   localparam logic [CNT_W:0]   HIGH_T  = (CNT_W+1)'(HIGH_COUNT);
   localparam logic [3:0]       INIT_T  = 4'(INIT_THRESHOLD);
   localparam logic [3:0]       TMIN_T  = 4'(THR_MIN);
   localparam logic [3:0]       TMAX_T  = 4'(THR_MAX);
   localparam logic [12:0]      DEF_Y_T = 13'(DEFAULT_Y);

   typedef enum logic [1:0] {WAIT_VS, CLEAR, ACCUM, UPDATE} state_t;

   state_t           state;
   logic             vs_q;
   logic             vs_fall;
   logic [CNT_W-1:0] l_cnt, r_cnt;
   logic [12:0]      l_min, l_max, r_min, r_max;
   logic [CNT_W:0]   total;
   logic [13:0]      l_sum, r_sum;

   // col is carried only for debug taps
   logic unused_col;
   assign unused_col = ^col;

   always_comb begin
      vs_fall = vs_q & ~vs_n;
      total   = {1'b0, l_cnt} + {1'b0, r_cnt};
      l_sum   = {1'b0, l_min} + {1'b0, l_max};
      r_sum   = {1'b0, r_min} + {1'b0, r_max};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= WAIT_VS;
         vs_q        <= 1'b1;
         en_o        <= 1'b0;
         threshold_o <= INIT_T;
         left_y      <= DEF_Y_T;
         right_y     <= DEF_Y_T;
         left_valid  <= 1'b0;
         right_valid <= 1'b0;
         frame_done  <= 1'b0;
         l_cnt       <= '0;
         r_cnt       <= '0;
         l_min       <= 13'h1FFF;
         r_min       <= 13'h1FFF;
         l_max       <= '0;
         r_max       <= '0;
      end else begin
         vs_q       <= vs_n;
         frame_done <= 1'b0;
         case (state)
            WAIT_VS: begin
               if (vs_fall) state <= CLEAR;
            end
            CLEAR: begin
               l_cnt <= '0;
               r_cnt <= '0;
               l_min <= 13'h1FFF;
               r_min <= 13'h1FFF;
               l_max <= '0;
               r_max <= '0;
               en_o  <= 1'b1;
               state <= ACCUM;
            end
            ACCUM: begin
               // The pixel coinciding with the boundary belongs to no frame
               if (vs_fall) begin
                  state <= UPDATE;
               end else if (blank_n) begin
                  if (left_paddle) begin
                     if (l_cnt != '1) l_cnt <= l_cnt + 1'b1;
                     if (row < l_min) l_min <= row;
                     if (row > l_max) l_max <= row;
                  end
                  if (right_paddle) begin
                     if (r_cnt != '1) r_cnt <= r_cnt + 1'b1;
                     if (row < r_min) r_min <= row;
                     if (row > r_max) r_max <= row;
                  end
               end
            end
            UPDATE: begin
               left_valid  <= (l_cnt >= MIN_T);
               right_valid <= (r_cnt >= MIN_T);
               if (l_cnt >= MIN_T) left_y  <= l_sum[13:1];
               if (r_cnt >= MIN_T) right_y <= r_sum[13:1];
               if (manual_sw)
                  threshold_o <= threshold_sw;
               else if (total > HIGH_T && threshold_o < TMAX_T)
                  threshold_o <= threshold_o + 1'b1;
               else if (total < LOW_T && threshold_o > TMIN_T)
                  threshold_o <= threshold_o - 1'b1;
               frame_done <= 1'b1;
               state      <= CLEAR;
            end
            default: state <= WAIT_VS;
         endcase
      end
   end

endmodule

// File: tb/tb_denoise_frame_ctrl.sv
// tb/tb_denoise_frame_ctrl.sv - scoreboard bench for denoise_frame_ctrl
module tb_denoise_frame_ctrl;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        vs_n = 1'b1;
   logic        blank_n = 1'b0;
   logic        left_paddle = 1'b0;
   logic        right_paddle = 1'b0;
   logic [12:0] row = '0;
   logic [12:0] col = '0;
   logic        manual_sw = 1'b0;
   logic [3:0]  threshold_sw = '0;
   logic        en_o;
   logic [3:0]  threshold_o;
   logic [12:0] left_y, right_y;
   logic        left_valid, right_valid, frame_done;

   denoise_frame_ctrl dut (
      .clk(clk), .reset(reset), .vs_n(vs_n), .blank_n(blank_n),
      .left_paddle(left_paddle), .right_paddle(right_paddle),
      .row(row), .col(col), .manual_sw(manual_sw), .threshold_sw(threshold_sw),
      .en_o(en_o), .threshold_o(threshold_o), .left_y(left_y), .right_y(right_y),
      .left_valid(left_valid), .right_valid(right_valid), .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [12:0] ly;
      logic [12:0] ry;
      logic        lv;
      logic        rv;
      logic [3:0]  thr;
   } exp_t;

   exp_t sb[$];
   int checks = 0;
   int failures = 0;

   int m_thr, m_ly, m_ry;
   int a_lcnt, a_rcnt, a_lmin, a_lmax, a_rmin, a_rmax;

   task automatic clear_acc();
      a_lcnt = 0; a_rcnt = 0;
      a_lmin = 8191; a_rmin = 8191;
      a_lmax = 0; a_rmax = 0;
   endtask

   task automatic idle_inputs();
      blank_n = 0; left_paddle = 0; right_paddle = 0; row = 0;
   endtask

   // Each row begins with a blanked cycle carrying masks on row 0, which must be ignored
   task automatic pixels(input bit side_r, input int r0, input int nr, input int nc);
      for (int r = r0; r < r0 + nr; r++) begin
         @(negedge clk);
         blank_n = 0; left_paddle = 1; right_paddle = 1; row = 0;
         for (int c = 0; c < nc; c++) begin
            @(negedge clk);
            blank_n = 1; row = 13'(r); col = 13'(c);
            left_paddle = !side_r; right_paddle = side_r;
            if (side_r) begin
               a_rcnt++;
               if (r < a_rmin) a_rmin = r;
               if (r > a_rmax) a_rmax = r;
            end else begin
               a_lcnt++;
               if (r < a_lmin) a_lmin = r;
               if (r > a_lmax) a_lmax = r;
            end
         end
      end
      @(negedge clk);
      idle_inputs();
   endtask

   // Frame boundary from WAIT_VS: enables the filter but publishes nothing
   task automatic start_frame();
      int pulses = 0;
      @(negedge clk);
      vs_n = 0; blank_n = 1; left_paddle = 1; right_paddle = 1; row = 1;
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk);
         if (frame_done) pulses++;
         if (i == 1) begin
            checks++;
            if (en_o !== 1'b0) begin failures++; $display("FAIL en_before_clear got=%b exp=0", en_o); end
         end
         if (i == 2) begin
            checks++;
            if (en_o !== 1'b1) begin failures++; $display("FAIL en_after_clear got=%b exp=1", en_o); end
         end
         vs_n = (i < 3) ? 1'b0 : 1'b1;
         idle_inputs();
      end
      checks++;
      if (pulses != 0) begin failures++; $display("FAIL no_done_on_start got=%0d exp=0", pulses); end
      clear_acc();
   endtask

   task automatic end_frame();
      exp_t e, g;
      int total, lat, pulses;
      e.lv = (a_lcnt >= 64);
      e.rv = (a_rcnt >= 64);
      e.ly = e.lv ? 13'((a_lmin + a_lmax) / 2) : 13'(m_ly);
      e.ry = e.rv ? 13'((a_rmin + a_rmax) / 2) : 13'(m_ry);
      total = a_lcnt + a_rcnt;
      if (manual_sw) e.thr = threshold_sw;
      else if (total > 6000 && m_thr < 15) e.thr = 4'(m_thr + 1);
      else if (total < 400 && m_thr > 1) e.thr = 4'(m_thr - 1);
      else e.thr = 4'(m_thr);
      m_thr = e.thr; m_ly = e.ly; m_ry = e.ry;
      sb.push_back(e);
      @(negedge clk);
      vs_n = 0; blank_n = 1; left_paddle = 1; right_paddle = 1; row = 1;
      lat = 0; pulses = 0;
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk);
         if (frame_done) begin
            pulses++;
            if (lat == 0) lat = i;
            if (sb.size() > 0) begin
               g = sb.pop_front();
               checks += 5;
               if (left_y !== g.ly) begin failures++; $display("FAIL left_y got=%0d exp=%0d", left_y, g.ly); end
               if (right_y !== g.ry) begin failures++; $display("FAIL right_y got=%0d exp=%0d", right_y, g.ry); end
               if (left_valid !== g.lv) begin failures++; $display("FAIL left_valid got=%b exp=%b", left_valid, g.lv); end
               if (right_valid !== g.rv) begin failures++; $display("FAIL right_valid got=%b exp=%b", right_valid, g.rv); end
               if (threshold_o !== g.thr) begin failures++; $display("FAIL threshold got=%0d exp=%0d", threshold_o, g.thr); end
            end
         end
         vs_n = (i < 3) ? 1'b0 : 1'b1;
         idle_inputs();
      end
      checks += 2;
      if (lat != 2) begin failures++; $display("FAIL done_latency got=%0d exp=2", lat); end
      if (pulses != 1) begin failures++; $display("FAIL done_width got=%0d exp=1", pulses); end
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_left got=%0d exp=0", sb.size());
         sb.delete();
      end
      clear_acc();
   endtask

   task automatic check_thr_hold(input string name);
      checks++;
      if (threshold_o !== 4'(m_thr)) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d", name, threshold_o, m_thr);
      end
   endtask

   task automatic check_reset_values(input string name);
      checks++;
      if (en_o !== 1'b0 || threshold_o !== 4'd8 || left_y !== 13'd240 || right_y !== 13'd240 ||
          left_valid !== 1'b0 || right_valid !== 1'b0 || frame_done !== 1'b0) begin
         failures++;
         $display("FAIL %s got=en%b thr%0d ly%0d ry%0d lv%b rv%b fd%b exp=en0 thr8 ly240 ry240 lv0 rv0 fd0",
                  name, en_o, threshold_o, left_y, right_y, left_valid, right_valid, frame_done);
      end
      m_thr = 8; m_ly = 240; m_ry = 240;
   endtask

   task automatic test_reset();
      reset = 1;
      repeat (3) @(negedge clk);
      check_reset_values("reset_values");
      reset = 0;
      clear_acc();
      // Partial frame before the first boundary must be discarded
      pixels(1'b0, 0, 5, 20);
      checks++;
      if (en_o !== 1'b0) begin failures++; $display("FAIL en_wait_vs got=%b exp=0", en_o); end
      start_frame();
   endtask

   task automatic test_first_frame();
      pixels(1'b0, 100, 40, 20);
      end_frame();
   endtask

   task automatic test_thr_up();
      pixels(1'b0, 200, 70, 50);
      pixels(1'b1, 300, 70, 50);
      end_frame();
   endtask

   task automatic test_manual(input int val, input bit big);
      pixels(1'b0, 200, 35, 50);
      manual_sw = 1; threshold_sw = 4'(val);
      @(negedge clk);
      check_thr_hold("thr_mid_frame");
      if (big) begin
         pixels(1'b0, 235, 35, 50);
         pixels(1'b1, 300, 70, 50);
      end
      end_frame();
      check_thr_hold("thr_after_manual");
   endtask

   task automatic test_thr_sat_high();
      manual_sw = 0;
      pixels(1'b0, 200, 70, 50);
      pixels(1'b1, 300, 70, 50);
      end_frame();
   endtask

   task automatic test_empty_frames();
      manual_sw = 1; threshold_sw = 4'd3;
      pixels(1'b0, 100, 40, 20);
      end_frame();
      threshold_sw = 4'd1;
      end_frame();
      manual_sw = 0;
      pixels(1'b0, 10, 63, 1);
      end_frame();
      manual_sw = 1; threshold_sw = 4'd5;
      pixels(1'b0, 300, 64, 1);
      pixels(1'b1, 50, 10, 10);
      end_frame();
      manual_sw = 0;
      end_frame();
   endtask

   task automatic test_reset_mid_frame();
      pixels(1'b0, 0, 5, 10);
      @(negedge clk);
      reset = 1;
      @(negedge clk);
      reset = 0;
      check_reset_values("reset_mid_frame");
      clear_acc();
      pixels(1'b1, 0, 3, 10);
      start_frame();
      pixels(1'b0, 100, 40, 20);
      end_frame();
   endtask

   initial begin
      clear_acc();
      test_reset();
      test_first_frame();
      test_thr_up();
      test_manual(15, 1'b1);
      test_thr_sat_high();
      test_empty_frames();
      test_reset_mid_frame();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

endmodule
